// File: rtl/hyper_mem_responder.sv
// -----------------------------------------------------------------------------
// hyper_mem_responder
//   Device end of a HyperBus link at PHY abstraction. One clk_i cycle is one CK
//   period and each 16-bit word carries both DDR bytes ([15:8] rise, [7:0] fall).
//   Used as a fast memory target in controller benches and FPGA emulation.
//
//   Cycle cN is the cycle whose rising edge samples CA word N. Outputs are
//   registered and are valid after that edge.
//
// Ports
//   clk_i      in   1   CK-equivalent clock
//   rst_ni     in   1   asynchronous active-low reset
//   cs_ni      in   1   chip select, active low
//   dq_i       in   16  CA words / write data from the controller
//   rwds_i     in   2   write byte mask during write data (1 = masked)
//   dq_o       out  16  read data
//   dq_oe_o    out  1   responder drives dq_o
//   rwds_o     out  1   CA phase: latency flag (1 = 2x); read phase: valid strobe
//   rwds_oe_o  out  1   responder drives rwds_o
// -----------------------------------------------------------------------------
module hyper_mem_responder #(
    parameter int          MEM_WORDS  = 1024,
    parameter int          LATENCY    = 6,
    parameter int          FIXED_2X   = 1,
    parameter int          WRAP_WORDS = 16,
    parameter logic [15:0] ID0_VAL    = 16'h0C81,
    parameter logic [15:0] CR0_RST    = 16'h8F1F
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cs_ni,
    input  logic [15:0] dq_i,
    input  logic [1:0]  rwds_i,
    output logic [15:0] dq_o,
    output logic        dq_oe_o,
    output logic        rwds_o,
    output logic        rwds_oe_o
);

    localparam int          LAT_CYC  = LATENCY * ((FIXED_2X != 0) ? 2 : 1);
    localparam int          AW       = $clog2(MEM_WORDS);
    localparam int          WB       = $clog2(WRAP_WORDS);
    localparam int          CW       = 16;
    localparam logic [CW-1:0] LAT_LAST = CW'(LAT_CYC - 1);
    localparam logic        LAT_FLAG = (FIXED_2X != 0);
    localparam logic [31:0] ID0_ADDR = 32'h0000_0000;
    localparam logic [31:0] CR0_ADDR = 32'h0000_0800;

    typedef enum logic [2:0] {
        IDLE,
        CA,
        LAT,
        REGW,
        WDATA,
        RDATA,
        HOLD
    } state_t;

    state_t         state, state_nx;
    logic [CW-1:0]  cnt;
    logic [15:0]    ca_w0;
    logic [15:0]    ca_w1;
    logic           is_read;
    logic           is_reg;
    logic           is_lin;
    logic [31:0]    addr;
    logic [31:0]    addr_nx;
    logic [15:0]    cr0;
    logic [15:0]    rd_word;
    logic [15:0]    mem [MEM_WORDS];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_nx;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: state_nx gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nx = state;
        if (cs_ni) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE: state_nx = CA;
                CA: begin
                    // Second cycle in CA captures the final CA word. A register
                    // write has zero latency; everything else waits LAT_CYC.
                    if (cnt == CW'(1))
                        state_nx = (!ca_w0[15] && ca_w0[14]) ? REGW : LAT;
                end
                LAT:   if (cnt == LAT_LAST) state_nx = is_read ? RDATA : WDATA;
                REGW:  state_nx = HOLD;
                WDATA: state_nx = WDATA;
                RDATA: state_nx = RDATA;
                HOLD:  state_nx = HOLD;
                default: state_nx = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Address advance and read-word selection
    // ------------------------------------------------------------------
    always_comb begin
        addr_nx = addr;
        if (is_reg)
            addr_nx = addr;                      // register bursts repeat the word
        else if (is_lin)
            addr_nx = addr + 32'd1;              // low AW bits wrap mod MEM_WORDS
        else
            addr_nx = {addr[31:WB], addr[WB-1:0] + WB'(1)};
    end

    always_comb begin
        rd_word = mem[addr[AW-1:0]];
        if (is_reg) begin
            if (addr == ID0_ADDR)      rd_word = ID0_VAL;
            else if (addr == CR0_ADDR) rd_word = cr0;
            else                       rd_word = 16'h0000;
        end
    end

    // ------------------------------------------------------------------
    // Datapath: CA capture, counters, CR0, registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt       <= '0;
            ca_w0     <= '0;
            ca_w1     <= '0;
            is_read   <= 1'b0;
            is_reg    <= 1'b0;
            is_lin    <= 1'b0;
            addr      <= '0;
            cr0       <= CR0_RST;
            dq_o      <= '0;
            dq_oe_o   <= 1'b0;
            rwds_o    <= 1'b0;
            rwds_oe_o <= 1'b0;
        end else begin
            // Counter restarts on every state change, so it counts cycles
            // spent in the current state.
            cnt       <= (state_nx != state) ? '0 : cnt + CW'(1);
            dq_o      <= '0;
            dq_oe_o   <= 1'b0;
            rwds_o    <= 1'b0;
            rwds_oe_o <= 1'b0;
            if (!cs_ni) begin
                unique case (state)
                    IDLE: begin
                        ca_w0     <= dq_i;
                        rwds_oe_o <= 1'b1;
                        rwds_o    <= LAT_FLAG;
                    end
                    CA: begin
                        rwds_oe_o <= 1'b1;
                        rwds_o    <= LAT_FLAG;
                        if (cnt == '0) begin
                            ca_w1 <= dq_i;
                        end else begin
                            is_read <= ca_w0[15];
                            is_reg  <= ca_w0[14];
                            is_lin  <= ca_w0[13];
                            addr    <= {ca_w0[12:0], ca_w1, dq_i[2:0]};
                        end
                    end
                    REGW: if (addr == CR0_ADDR) cr0 <= dq_i;
                    RDATA: begin
                        dq_o      <= rd_word;
                        dq_oe_o   <= 1'b1;
                        rwds_oe_o <= 1'b1;
                        rwds_o    <= 1'b1;
                        addr      <= addr_nx;
                    end
                    WDATA: addr <= addr_nx;
                    default: ;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Backing store with per-byte write mask
    // ------------------------------------------------------------------
    // NOTE: the memory array has no reset; clearing it would need a
    // sequencer and its contents must survive rst_ni anyway.
    always_ff @(posedge clk_i) begin
        if (state == WDATA && !cs_ni) begin
            if (!rwds_i[1]) mem[addr[AW-1:0]][15:8] <= dq_i[15:8];
            if (!rwds_i[0]) mem[addr[AW-1:0]][7:0]  <= dq_i[7:0];
        end
    end

endmodule

// File: tb/tb_hyper_mem_responder.sv
module tb_hyper_mem_responder;

    localparam int          MEM_WORDS  = 1024;
    localparam int          LATENCY    = 6;
    localparam int          FIXED_2X   = 1;
    localparam int          WRAP_WORDS = 16;
    localparam logic [15:0] ID0_VAL    = 16'h0C81;
    localparam logic [15:0] CR0_RST    = 16'h8F1F;
    localparam int          LAT_CYC    = (FIXED_2X != 0) ? 2 * LATENCY : LATENCY;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        cs_ni;
    logic [15:0] dq_i;
    logic [1:0]  rwds_i;
    logic [15:0] dq_o;
    logic        dq_oe_o;
    logic        rwds_o;
    logic        rwds_oe_o;

    hyper_mem_responder #(
        .MEM_WORDS (MEM_WORDS),
        .LATENCY   (LATENCY),
        .FIXED_2X  (FIXED_2X),
        .WRAP_WORDS(WRAP_WORDS),
        .ID0_VAL   (ID0_VAL),
        .CR0_RST   (CR0_RST)
    ) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .cs_ni    (cs_ni),
        .dq_i     (dq_i),
        .rwds_i   (rwds_i),
        .dq_o     (dq_o),
        .dq_oe_o  (dq_oe_o),
        .rwds_o   (rwds_o),
        .rwds_oe_o(rwds_oe_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference state: memory image and CR0 value as the controller sees them.
    logic [15:0] m_mem [MEM_WORDS];
    logic [15:0] m_cr0;
    // Per-transaction write data and byte masks.
    logic [15:0] wd [MEM_WORDS];
    logic [1:0]  wm [MEM_WORDS];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock and sample just after the edge; inputs are then
    // changed in the same gap, well before the next edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Word address of beat i of a burst starting at a.
    function automatic int unsigned beat_addr(input logic [31:0] a, input int i, input bit lin);
        logic [31:0] base;
        logic [31:0] off;
        if (lin) return (a + 32'(i)) % MEM_WORDS;
        base = a & ~32'(WRAP_WORDS - 1);
        off  = (a + 32'(i)) & 32'(WRAP_WORDS - 1);
        return (base | off) % MEM_WORDS;
    endfunction

    function automatic logic [15:0] reg_val(input logic [31:0] a);
        if (a == 32'h0)   return ID0_VAL;
        if (a == 32'h800) return m_cr0;
        return 16'h0000;
    endfunction

    // One complete transaction: CA, latency, n data beats, one idle cycle.
    // rst_at >= 0 pulses rst_ni right after read beat rst_at and ends early.
    task automatic txn(input bit rd, input bit rg, input bit lin,
                       input logic [31:0] a, input int n, input int rst_at);
        logic [47:0] ca;
        logic [15:0] exp;
        int unsigned ma;
        ca = {rd, rg, lin, a[31:3], 13'b0, a[2:0]};
        for (int k = 0; k < 3; k++) begin
            cs_ni  = 1'b0;
            dq_i   = ca[47 - 16 * k -: 16];
            rwds_i = 2'(k);
            step();
            check("ca_rwds_oe", 32'(rwds_oe_o), 32'd1);
            check("ca_rwds_flag", 32'(rwds_o), 32'(FIXED_2X != 0));
        end
        if (!rd && rg) begin
            dq_i = wd[0];
            step();
            if (a == 32'h800) m_cr0 = wd[0];
            check("regw_dq_oe", 32'(dq_oe_o), 32'd0);
            check("regw_rwds_oe", 32'(rwds_oe_o), 32'd0);
        end else begin
            for (int l = 0; l < LAT_CYC; l++) begin
                dq_i   = 16'($urandom);
                rwds_i = 2'($urandom);
                step();
                check("lat_dq_oe", 32'(dq_oe_o), 32'd0);
                check("lat_rwds_oe", 32'(rwds_oe_o), 32'd0);
            end
            for (int i = 0; i < n; i++) begin
                ma = beat_addr(a, i, lin);
                if (rd) begin
                    dq_i   = 16'($urandom);
                    rwds_i = 2'($urandom);
                    step();
                    exp = rg ? reg_val(a) : m_mem[ma];
                    check("rd_data", 32'(dq_o), 32'(exp));
                    check("rd_dq_oe", 32'(dq_oe_o), 32'd1);
                    check("rd_rwds_oe", 32'(rwds_oe_o), 32'd1);
                    check("rd_rwds", 32'(rwds_o), 32'd1);
                    if (i == rst_at) begin
                        #2;
                        rst_ni = 1'b0;
                        #1;
                        check("rst_dq_oe", 32'(dq_oe_o), 32'd0);
                        check("rst_rwds_oe", 32'(rwds_oe_o), 32'd0);
                        check("rst_dq", 32'(dq_o), 32'd0);
                        m_cr0 = CR0_RST;
                        cs_ni = 1'b1;
                        step();
                        rst_ni = 1'b1;
                        step();
                        return;
                    end
                end else begin
                    dq_i   = wd[i];
                    rwds_i = wm[i];
                    step();
                    if (!wm[i][1]) m_mem[ma][15:8] = wd[i][15:8];
                    if (!wm[i][0]) m_mem[ma][7:0]  = wd[i][7:0];
                    check("wr_dq_oe", 32'(dq_oe_o), 32'd0);
                end
            end
        end
        cs_ni  = 1'b1;
        dq_i   = 16'($urandom);
        rwds_i = 2'b00;
        step();
        check("end_dq_oe", 32'(dq_oe_o), 32'd0);
        check("end_rwds_oe", 32'(rwds_oe_o), 32'd0);
    endtask

    initial begin
        rst_ni = 1'b0;
        cs_ni  = 1'b1;
        dq_i   = '0;
        rwds_i = '0;
        m_cr0  = CR0_RST;
        repeat (2) step();
        check("reset_dq", 32'(dq_o), 32'd0);
        check("reset_dq_oe", 32'(dq_oe_o), 32'd0);
        check("reset_rwds", 32'(rwds_o), 32'd0);
        check("reset_rwds_oe", 32'(rwds_oe_o), 32'd0);
        rst_ni = 1'b1;
        step();

        // Fill the whole store with distinct words so every later read is known.
        for (int i = 0; i < MEM_WORDS; i++) begin
            wd[i] = 16'(i * 16'h9E37 + 16'h1234);
            wm[i] = 2'b00;
        end
        txn(1'b0, 1'b0, 1'b1, 32'h0, MEM_WORDS, -1);

        // Linear write then read of four words at 0x10.
        for (int i = 0; i < 4; i++) begin
            wd[i] = 16'h1111 * 16'(i + 1);
            wm[i] = 2'b00;
        end
        txn(1'b0, 1'b0, 1'b1, 32'h10, 4, -1);
        txn(1'b1, 1'b0, 1'b1, 32'h10, 4, -1);

        // Byte-masked write over a known word.
        wd[0] = 16'h1234; wm[0] = 2'b00;
        txn(1'b0, 1'b0, 1'b1, 32'h20, 1, -1);
        wd[0] = 16'hABCD; wm[0] = 2'b10;
        txn(1'b0, 1'b0, 1'b1, 32'h20, 1, -1);
        txn(1'b1, 1'b0, 1'b1, 32'h20, 1, -1);

        // Wrapped read crossing the 16-word boundary.
        txn(1'b1, 1'b0, 1'b0, 32'h0E, 6, -1);

        // Register space: ID0, CR0 write/readback, ignored ID0 write.
        txn(1'b1, 1'b1, 1'b1, 32'h0, 2, -1);
        wd[0] = 16'h8F2F;
        txn(1'b0, 1'b1, 1'b1, 32'h800, 0, -1);
        txn(1'b1, 1'b1, 1'b1, 32'h800, 2, -1);
        wd[0] = 16'hFFFF;
        txn(1'b0, 1'b1, 1'b1, 32'h0, 0, -1);
        txn(1'b1, 1'b1, 1'b1, 32'h0, 1, -1);

        // Write burst cut short after two words, then read four back.
        wd[0] = 16'hAAAA; wd[1] = 16'hBBBB; wm[0] = 2'b00; wm[1] = 2'b00;
        txn(1'b0, 1'b0, 1'b1, 32'h10, 2, -1);
        txn(1'b1, 1'b0, 1'b1, 32'h10, 4, -1);

        // Reset in the middle of a read; CR0 returns to reset value, memory stays.
        txn(1'b1, 1'b0, 1'b1, 32'h100, 6, 2);
        txn(1'b1, 1'b1, 1'b1, 32'h800, 1, -1);
        txn(1'b1, 1'b0, 1'b1, 32'h10, 4, -1);

        // Randomized mix of memory and register transactions.
        for (int t = 0; t < 40; t++) begin
            int          kind;
            int          n;
            logic [31:0] ra;
            kind = int'($urandom_range(0, 9));
            case ($urandom_range(0, 2))
                0:       ra = 32'h0;
                1:       ra = 32'h800;
                default: ra = 32'h5;
            endcase
            if (kind == 0) begin
                wd[0] = 16'($urandom);
                txn(1'b0, 1'b1, 1'b1, ra, 0, -1);
            end else if (kind == 1) begin
                txn(1'b1, 1'b1, 1'b1, ra, int'($urandom_range(1, 3)), -1);
            end else begin
                n = int'($urandom_range(1, 8));
                for (int i = 0; i < n; i++) begin
                    wd[i] = 16'($urandom);
                    wm[i] = 2'($urandom);
                end
                txn(1'($urandom), 1'b0, 1'($urandom), $urandom, n, -1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
